food_map: RTL and testbench

- Upstream feeder of the food sprite layout stage.
- Holds the per-cell food type (2-bit ftype: 0 = empty, 1/2/3 = small/medium/large) for the whole maze grid.
- Serves a registered read port to the pixel renderer, which passes the returned ftype to the sprite layout.
- Services "eat" requests from the player-movement logic, accumulates score, and refills the map when all food is eaten.

---
 rtl/food_map_pkg.sv | 44 ++++
 rtl/food_map_lfsr.sv | 31 +++
 rtl/food_map.sv | 249 ++++++++++++++++++++++++
 tb/tb_food_map.sv | 326 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/food_map_pkg.sv
// food_map_pkg: shared encodings for the food map.
// Holds the cell food types, FSM state codes, fill-LFSR taps and
// the helpers that turn LFSR state or a food type into a value.
package food_map_pkg;

    // Per-cell food type stored in the map
    typedef enum logic [1:0] {
        FT_EMPTY = 2'd0,
        FT_SMALL = 2'd1,
        FT_MED   = 2'd2,
        FT_LARGE = 2'd3
    } ftype_t;

    // Controller states; the RSP_* pair is only reachable when respawn is built in
    typedef enum logic [2:0] {
        ST_FILL   = 3'd0,
        ST_IDLE   = 3'd1,
        ST_EAT_RD = 3'd2,
        ST_EAT_WR = 3'd3,
        ST_RSP_RD = 3'd4,
        ST_RSP_WR = 3'd5
    } state_t;

    // x^8 + x^6 + x^5 + x^4 + 1 -> feedback from bits 7,5,4,3
    localparam logic [7:0] LFSR_TAPS = 8'hB8;

    // Points for eating a cell: 1/2/4 for small/medium/large, 0 for empty
    function automatic logic [2:0] ft_points(input logic [1:0] ft);
        logic [2:0] pts;
        case (ft)
            FT_SMALL: pts = 3'd1;
            FT_MED:   pts = 3'd2;
            FT_LARGE: pts = 3'd4;
            default:  pts = 3'd0;
        endcase
        return pts;
    endfunction

    // Food type derived from the low LFSR bits; a zero pattern becomes small
    function automatic logic [1:0] lfsr_ftype(input logic [7:0] l);
        return (l[1:0] == FT_EMPTY) ? FT_SMALL : l[1:0];
    endfunction

endpackage

// File: rtl/food_map_lfsr.sv
// food_map_lfsr: 8-bit Fibonacci LFSR used to pick food types.
// load has priority over adv so a re-seed never also steps the sequence.
module food_map_lfsr
    import food_map_pkg::*;
#(
    parameter logic [7:0] SEED = 8'hA5
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       load,
    input  logic [7:0] load_val,
    input  logic       adv,
    output logic [7:0] value
);

    logic [7:0] lfsr_reg;

    // Shift register: reset to the seed, reload on request, otherwise step when enabled
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lfsr_reg <= SEED;
        end else if (load) begin
            lfsr_reg <= load_val;
        end else if (adv) begin
            lfsr_reg <= {lfsr_reg[6:0], ^(lfsr_reg & LFSR_TAPS)};
        end
    end

    assign value = lfsr_reg;

endmodule

// File: rtl/food_map.sv
// food_map: per-cell food storage for the maze, with a registered render
// read port, an eat/score engine and automatic refill when the map empties.
// Optional build macro FOOD_MAP_RESPAWN_EN adds a slow background scan that
// repopulates empty cells while the controller is idle.
module food_map
    import food_map_pkg::*;
#(
    parameter int         CX_W           = 4,
    parameter int         CY_W           = 4,
    parameter logic [7:0] LFSR_SEED      = 8'hA5,
    parameter int         SCORE_W        = 16,
    parameter int         RESPAWN_PERIOD = 1024
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [CX_W-1:0]        rd_cx,
    input  logic [CY_W-1:0]        rd_cy,
    output logic [1:0]             rd_ftype,
    input  logic                   eat_valid,
    input  logic [CX_W-1:0]        eat_cx,
    input  logic [CY_W-1:0]        eat_cy,
    output logic                   eat_ready,
    output logic                   eat_done,
    output logic                   eat_hit,
    output logic [2:0]             eat_points,
    output logic [SCORE_W-1:0]     score,
    output logic [CX_W+CY_W:0]     food_left,
    output logic [7:0]             level,
    output logic                   level_done,
    output logic                   ready
);

    localparam int               AW         = CX_W + CY_W;
    localparam int               CELLS      = 1 << AW;
    localparam int               FL_W       = AW + 1;
    localparam logic [AW-1:0]    LAST_CELL  = {AW{1'b1}};
    localparam logic [FL_W-1:0]  FULL_COUNT = FL_W'(CELLS);

    state_t              state_reg, state_next;
    logic [AW-1:0]       p_reg;
    logic [AW-1:0]       eat_addr_reg;
    logic [1:0]          mem [0:CELLS-1];
    logic [1:0]          rd_q_reg;
    logic [1:0]          int_q_reg;
    logic                mem_we;
    logic [AW-1:0]       int_addr;
    logic [1:0]          mem_wd;
    logic                lfsr_adv;
    logic                lfsr_load;
    logic [7:0]          lfsr_val;
    logic [7:0]          level_new;
    logic                cell_full;
    logic                last_food;
    logic [2:0]          pts_now;
    logic [SCORE_W:0]    score_sum;

    logic                ready_reg;
    logic                eat_done_reg;
    logic                eat_hit_reg;
    logic [2:0]          eat_points_reg;
    logic [SCORE_W-1:0]  score_reg;
    logic [FL_W-1:0]     food_left_reg;
    logic [7:0]          level_reg;
    logic                level_done_reg;

`ifdef FOOD_MAP_RESPAWN_EN
    localparam int RC_W = (RESPAWN_PERIOD > 1) ? $clog2(RESPAWN_PERIOD) : 1;
    logic [RC_W-1:0]     rsp_cnt_reg;
    logic                rsp_pending_reg;
    logic [AW-1:0]       s_reg;
    logic                rsp_fire;
    assign rsp_fire = (rsp_cnt_reg == RC_W'(RESPAWN_PERIOD - 1));
`endif

    // Cell read through the controller port, valid in the *_WR states
    assign cell_full = (int_q_reg != FT_EMPTY);
    assign last_food = cell_full && (food_left_reg == FL_W'(1));
    assign pts_now   = ft_points(int_q_reg);
    assign score_sum = {1'b0, score_reg} + {{(SCORE_W-2){1'b0}}, pts_now};
    assign level_new = level_reg + 8'd1;
    assign lfsr_load = (state_reg == ST_EAT_WR) && last_food;

    food_map_lfsr #(
        .SEED     (LFSR_SEED)
    ) u_lfsr (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (lfsr_load),
        .load_val (LFSR_SEED ^ level_new),
        .adv      (lfsr_adv),
        .value    (lfsr_val)
    );

    // Render port: registered read; a same-cycle write to the cell returns old data
    always_ff @(posedge clk) begin
        rd_q_reg <= mem[{rd_cy, rd_cx}];
    end

    // Controller port: one read/write access per cycle
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[int_addr] <= mem_wd;
        end
        int_q_reg <= mem[int_addr];
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= ST_FILL;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic; a pending respawn yields to a concurrent eat request
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_FILL:   if (p_reg == LAST_CELL) state_next = ST_IDLE;
            ST_IDLE: begin
                if (eat_valid) begin
                    state_next = ST_EAT_RD;
                end
`ifdef FOOD_MAP_RESPAWN_EN
                else if (rsp_pending_reg) begin
                    state_next = ST_RSP_RD;
                end
`endif
            end
            ST_EAT_RD: state_next = ST_EAT_WR;
            ST_EAT_WR: state_next = last_food ? ST_FILL : ST_IDLE;
`ifdef FOOD_MAP_RESPAWN_EN
            ST_RSP_RD: state_next = ST_RSP_WR;
            ST_RSP_WR: state_next = ST_IDLE;
`endif
            default:   state_next = ST_FILL;
        endcase
    end

    // State outputs: handshake, controller memory port and LFSR stepping
    always_comb begin
        eat_ready = 1'b0;
        mem_we    = 1'b0;
        int_addr  = eat_addr_reg;
        mem_wd    = FT_EMPTY;
        lfsr_adv  = 1'b0;
        case (state_reg)
            ST_FILL: begin
                int_addr = p_reg;
                mem_we   = 1'b1;
                mem_wd   = lfsr_ftype(lfsr_val);
                lfsr_adv = 1'b1;
            end
            ST_IDLE:   eat_ready = 1'b1;
            ST_EAT_WR: mem_we = cell_full;
`ifdef FOOD_MAP_RESPAWN_EN
            ST_RSP_RD: int_addr = s_reg;
            ST_RSP_WR: begin
                int_addr = s_reg;
                mem_we   = !cell_full;
                mem_wd   = lfsr_ftype(lfsr_val);
                lfsr_adv = !cell_full;
            end
`endif
            default: ;
        endcase
    end

    // Datapath: fill pointer, eat latch, score, food count, level and pulses
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            p_reg          <= '0;
            eat_addr_reg   <= '0;
            ready_reg      <= 1'b0;
            eat_done_reg   <= 1'b0;
            eat_hit_reg    <= 1'b0;
            eat_points_reg <= 3'd0;
            score_reg      <= '0;
            food_left_reg  <= '0;
            level_reg      <= 8'd0;
            level_done_reg <= 1'b0;
        end else begin
            eat_done_reg   <= (state_reg == ST_EAT_WR);
            eat_hit_reg    <= (state_reg == ST_EAT_WR) && cell_full;
            eat_points_reg <= (state_reg == ST_EAT_WR) ? pts_now : 3'd0;
            level_done_reg <= lfsr_load;

            if (state_reg == ST_FILL) begin
                p_reg <= p_reg + AW'(1);
                if (p_reg == LAST_CELL) begin
                    ready_reg     <= 1'b1;
                    food_left_reg <= FULL_COUNT;
                end
            end

            if (state_reg == ST_IDLE && eat_valid) begin
                eat_addr_reg <= {eat_cy, eat_cx};
            end

            if (state_reg == ST_EAT_WR && cell_full) begin
                food_left_reg <= food_left_reg - FL_W'(1);
                score_reg     <= score_sum[SCORE_W] ? {SCORE_W{1'b1}} : score_sum[SCORE_W-1:0];
                if (last_food) begin
                    ready_reg <= 1'b0;
                    level_reg <= level_new;
                end
            end

`ifdef FOOD_MAP_RESPAWN_EN
            if (state_reg == ST_RSP_WR && !cell_full) begin
                food_left_reg <= food_left_reg + FL_W'(1);
            end
`endif
        end
    end

`ifdef FOOD_MAP_RESPAWN_EN
    // Respawn timer, pending flag and scan pointer; a new tick wins over the clear
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_cnt_reg     <= '0;
            rsp_pending_reg <= 1'b0;
            s_reg           <= '0;
        end else begin
            rsp_cnt_reg <= rsp_fire ? '0 : rsp_cnt_reg + RC_W'(1);
            if (rsp_fire) begin
                rsp_pending_reg <= 1'b1;
            end else if (state_reg == ST_IDLE && !eat_valid && rsp_pending_reg) begin
                rsp_pending_reg <= 1'b0;
            end
            if (state_reg == ST_RSP_WR) begin
                s_reg <= s_reg + AW'(1);
            end
        end
    end
`endif

    assign rd_ftype   = ready_reg ? rd_q_reg : FT_EMPTY;
    assign ready      = ready_reg;
    assign eat_done   = eat_done_reg;
    assign eat_hit    = eat_hit_reg;
    assign eat_points = eat_points_reg;
    assign score      = score_reg;
    assign food_left  = food_left_reg;
    assign level      = level_reg;
    assign level_done = level_done_reg;

endmodule

// File: tb/tb_food_map.sv
// tb_food_map: directed, table-driven checks of food_map (4x4-bit grid).
module tb_food_map;

    localparam int CX_W  = 4;
    localparam int CY_W  = 4;
    localparam int CELLS = 256;
`ifdef FOOD_MAP_RESPAWN_EN
    localparam int RSP_P = 16;
`else
    localparam int RSP_P = 1024;
`endif

    logic        clk;
    logic        rst_n;
    logic [3:0]  rd_cx, rd_cy;
    logic [1:0]  rd_ftype;
    logic        eat_valid;
    logic [3:0]  eat_cx, eat_cy;
    logic        eat_ready, eat_done, eat_hit;
    logic [2:0]  eat_points;
    logic [15:0] score;
    logic [8:0]  food_left;
    logic [7:0]  level;
    logic        level_done, ready;

    food_map #(
        .CX_W           (CX_W),
        .CY_W           (CY_W),
        .LFSR_SEED      (8'hA5),
        .SCORE_W        (16),
        .RESPAWN_PERIOD (RSP_P)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .rd_cx      (rd_cx),
        .rd_cy      (rd_cy),
        .rd_ftype   (rd_ftype),
        .eat_valid  (eat_valid),
        .eat_cx     (eat_cx),
        .eat_cy     (eat_cy),
        .eat_ready  (eat_ready),
        .eat_done   (eat_done),
        .eat_hit    (eat_hit),
        .eat_points (eat_points),
        .score      (score),
        .food_left  (food_left),
        .level      (level),
        .level_done (level_done),
        .ready      (ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    logic [1:0] model_map [CELLS];
    int exp_score;
    int exp_left;

    typedef struct {
        logic [3:0] cx;
        logic [3:0] cy;
        logic       exp_hit;
        logic [2:0] exp_pts;
        int         exp_score;
        int         exp_left;
    } eat_vec_t;

    eat_vec_t vecs [5];

    task automatic check(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference fill: 8-bit LFSR x^8+x^6+x^5+x^4+1, low bits 0 map to small food
    task automatic model_fill(input logic [7:0] seed);
        logic [7:0] l;
        l = seed;
        for (int i = 0; i < CELLS; i++) begin
            model_map[i] = (l[1:0] == 2'd0) ? 2'd1 : l[1:0];
            l = {l[6:0], l[7] ^ l[5] ^ l[4] ^ l[3]};
        end
    endtask

    function automatic int pts_of(input logic [1:0] ft);
        return (ft == 2'd0) ? 0 : (1 << (ft - 1));
    endfunction

    task automatic check_all_zero(input string tag);
        check({tag, "_ready"},      ready,      0);
        check({tag, "_eat_ready"},  eat_ready,  0);
        check({tag, "_eat_done"},   eat_done,   0);
        check({tag, "_eat_hit"},    eat_hit,    0);
        check({tag, "_eat_points"}, eat_points, 0);
        check({tag, "_score"},      score,      0);
        check({tag, "_food_left"},  food_left,  0);
        check({tag, "_level"},      level,      0);
        check({tag, "_level_done"}, level_done, 0);
        check({tag, "_rd_ftype"},   rd_ftype,   0);
    endtask

    // Counts clock edges until ready rises; rd_ftype must stay 0 meanwhile
    task automatic wait_fill(input int start_cnt, input string tag);
        int cnt;
        int bad_rd;
        cnt = start_cnt;
        bad_rd = 0;
        while (!ready && cnt < 400) begin
            if (rd_ftype != 2'd0) bad_rd++;
            tick();
            cnt++;
        end
        check({tag, "_fill_cycles"}, cnt, 256);
        check({tag, "_rd_during_fill"}, bad_rd, 0);
    endtask

    task automatic readback(input string tag);
        int nz;
        nz = 0;
        for (int i = 0; i < CELLS; i++) begin
            rd_cx = i[3:0];
            rd_cy = i[7:4];
            tick();
            check({tag, "_rd_map"}, rd_ftype, model_map[i]);
            if (rd_ftype != 2'd0) nz++;
        end
        check({tag, "_nonzero_cells"}, nz, CELLS);
    endtask

    // One eat transaction; eat_done is expected exactly 3 cycles after acceptance
    task automatic do_eat(input logic [3:0] cx, input logic [3:0] cy,
                          output logic hit, output logic [2:0] pts, output logic lvl);
        int w;
        w = 0;
        while (!eat_ready && w < 50) begin
            tick();
            w++;
        end
        check("eat_ready", eat_ready, 1);
        eat_valid = 1'b1;
        eat_cx    = cx;
        eat_cy    = cy;
        tick();
        eat_valid = 1'b0;
        tick();
        check("eat_done_early", eat_done, 0);
        tick();
        check("eat_done", eat_done, 1);
        hit = eat_hit;
        pts = eat_points;
        lvl = level_done;
        $display("eat (%0d,%0d) hit=%0d points=%0d score=%0d food_left=%0d",
                 cx, cy, eat_hit, eat_points, score, food_left);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic       h;
        logic [2:0] p;
        logic       ld;
        int         addr;
        int         pulses;
        int         found;

        rst_n     = 1'b0;
        eat_valid = 1'b0;
        eat_cx    = '0;
        eat_cy    = '0;
        rd_cx     = '0;
        rd_cy     = '0;
        repeat (3) tick();
        check_all_zero("reset");

        // First fill after reset release
        rst_n = 1'b1;
        wait_fill(0, "fill0");
        check("fill0_food_left", food_left, 256);
        check("fill0_score", score, 0);
        check("fill0_level", level, 0);
        model_fill(8'hA5);
        readback("fill0");
        exp_score = 0;
        exp_left  = 256;

`ifndef FOOD_MAP_RESPAWN_EN
        // Table of eats: first eat, re-eat of the same cell, and corner cells
        vecs[0].cx = 4'd3;  vecs[0].cy = 4'd5;
        vecs[1].cx = 4'd3;  vecs[1].cy = 4'd5;
        vecs[2].cx = 4'd0;  vecs[2].cy = 4'd0;
        vecs[3].cx = 4'd15; vecs[3].cy = 4'd15;
        vecs[4].cx = 4'd10; vecs[4].cy = 4'd12;
        for (int v = 0; v < 5; v++) begin
            addr = {vecs[v].cy, vecs[v].cx};
            vecs[v].exp_hit = (model_map[addr] != 2'd0);
            vecs[v].exp_pts = 3'(pts_of(model_map[addr]));
            if (vecs[v].exp_hit) begin
                exp_score = exp_score + pts_of(model_map[addr]);
                exp_left  = exp_left - 1;
            end
            model_map[addr]    = 2'd0;
            vecs[v].exp_score  = exp_score;
            vecs[v].exp_left   = exp_left;
        end

        for (int v = 0; v < 5; v++) begin
            do_eat(vecs[v].cx, vecs[v].cy, h, p, ld);
            check("vec_hit", h, vecs[v].exp_hit);
            check("vec_points", p, vecs[v].exp_pts);
            check("vec_level_done", ld, 0);
            check("vec_score", score, vecs[v].exp_score);
            check("vec_food_left", food_left, vecs[v].exp_left);
            rd_cx = vecs[v].cx;
            rd_cy = vecs[v].cy;
            tick();
            check("vec_rd_after_eat", rd_ftype, 0);
        end

        // Render read of (7,2) held across the eat: write cycle returns old data
        addr  = 8'h27;
        rd_cx = 4'd7;
        rd_cy = 4'd2;
        do_eat(4'd7, 4'd2, h, p, ld);
        check("rbw_hit", h, 1);
        check("rbw_old_value", rd_ftype, model_map[addr]);
        exp_score = exp_score + pts_of(model_map[addr]);
        exp_left  = exp_left - 1;
        model_map[addr] = 2'd0;
        tick();
        check("rbw_new_value", rd_ftype, 0);
        check("rbw_score", score, exp_score);

        // Eat every remaining cell; only the final eat may pulse level_done
        pulses = 0;
        for (int i = 0; i < CELLS; i++) begin
            if (model_map[i] != 2'd0) begin
                do_eat(i[3:0], i[7:4], h, p, ld);
                exp_score = exp_score + pts_of(model_map[i]);
                exp_left  = exp_left - 1;
                check("all_hit", h, 1);
                check("all_points", p, pts_of(model_map[i]));
                check("all_level_done", ld, (exp_left == 0) ? 1 : 0);
                model_map[i] = 2'd0;
                if (ld) pulses++;
            end
        end
        check("all_pulses", pulses, 1);
        check("all_level", level, 1);
        check("all_ready_low", ready, 0);
        check("all_food_left", food_left, 0);
        check("all_rd_gated", rd_ftype, 0);
        check("all_score", score, exp_score);
        tick();
        check("all_level_done_clear", level_done, 0);
        wait_fill(1, "fill1");
        check("fill1_food_left", food_left, 256);
        check("fill1_score_kept", score, exp_score);
        check("fill1_level", level, 1);
        model_fill(8'hA5 ^ 8'h01);
        readback("fill1");
`else
        // Empty cell (3,5), then wait for the background scan to repopulate it
        do_eat(4'd3, 4'd5, h, p, ld);
        check("rsp_eat_hit", h, 1);
        check("rsp_food_left", food_left, 255);
        rd_cx = 4'd3;
        rd_cy = 4'd5;
        tick();
        check("rsp_emptied", rd_ftype, 0);
        found = 0;
        for (int c = 0; c < 8000 && found == 0; c++) begin
            tick();
            if (rd_ftype != 2'd0) found = 1;
        end
        check("rsp_refilled", found, 1);
        check("rsp_food_left_back", food_left, 256);
`endif

        // Reset in the middle of an eat: everything clears and fill restarts
        begin
            int w;
            w = 0;
            while (!eat_ready && w < 50) begin
                tick();
                w++;
            end
        end
        check("mid_eat_ready", eat_ready, 1);
        eat_valid = 1'b1;
        eat_cx    = 4'd3;
        eat_cy    = 4'd5;
        tick();
        eat_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        check_all_zero("mid_reset");
        tick();
        rst_n = 1'b1;
        wait_fill(0, "fill2");
        check("fill2_food_left", food_left, 256);
        check("fill2_score", score, 0);
        check("fill2_level", level, 0);
        check("fill2_eat_done", eat_done, 0);
        model_fill(8'hA5);
        readback("fill2");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
